rr_mux32_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream resource (memory port or shared bus) among 32 requesters.
- Produces the 5-bit select that steers the 32:1 datapath mux, plus a valid strobe to the resource.
- Holds the grant until the resource signals completion, then acks the winner for one cycle.
- Sits between the requester array and the shared resource's request/response pins.

---
 rtl/rr_mux32_arbiter.sv | 150 +++++++++++++++
 tb/tb_rr_mux32_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rr_mux32_arbiter.sv
// Round-robin arbiter sharing one resource among 32 requesters; holds the grant until resp_in, then acks.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN (TIMEOUT_CYCLES busy cycles without a response).
module rr_mux32_arbiter #(
  parameter int NUM_REQ        = 32,
  parameter int SEL_WIDTH      = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_in,
  input  logic                 resp_in,
  output logic [SEL_WIDTH-1:0] sel_out,
  output logic                 valid_out,
  output logic [NUM_REQ-1:0]   ack_out,
  output logic                 busy_out,
  output logic                 timeout_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r, state_nxt;
  logic [SEL_WIDTH-1:0] ptr_r, ptr_nxt;
  logic [SEL_WIDTH-1:0] sel_r, sel_nxt;
  logic                 valid_r, valid_nxt;
  logic                 busy_r, busy_nxt;
  logic [NUM_REQ-1:0]   ack_r, ack_nxt;
  logic                 timeout_r, timeout_nxt;
  logic                 found_s;
  logic [SEL_WIDTH-1:0] win_s;
  logic                 timeout_hit_s;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_WIDTH-1:0] idx);
    onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Rotating priority scan: first set request at or above ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [SEL_WIDTH-1:0] idx_v;
    found_s = 1'b0;
    win_s   = ptr_r;
    idx_v   = ptr_r;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_v = ptr_r + SEL_WIDTH'(i);
      if (!found_s && req_in[idx_v]) begin
        found_s = 1'b1;
        win_s   = idx_v;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_r;

  // Watchdog: zero outside BUSY, counts BUSY cycles that end without a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_r <= '0;
    end else if (state_r != BUSY) begin
      wd_r <= '0;
    end else if (!resp_in) begin
      wd_r <= wd_r + WD_W'(1);
    end
  end

  assign timeout_hit_s = (wd_r == WD_LAST);
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Next-state and next-output logic; all outputs are taken from registers.
  always_comb begin
    state_nxt   = state_r;
    ptr_nxt     = ptr_r;
    sel_nxt     = sel_r;
    valid_nxt   = 1'b0;
    busy_nxt    = 1'b0;
    ack_nxt     = '0;
    timeout_nxt = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          sel_nxt   = win_s;
          state_nxt = BUSY;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        // Completion beats both a same-cycle abort and a same-cycle watchdog expiry.
        if (resp_in) begin
          state_nxt = DONE;
          ack_nxt   = onehot(sel_r);
        end else if (!req_in[sel_r]) begin
          state_nxt = IDLE;
        end else if (timeout_hit_s) begin
          state_nxt   = IDLE;
          timeout_nxt = 1'b1;
          ptr_nxt     = sel_r + SEL_WIDTH'(1);
        end else begin
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      DONE: begin
        ptr_nxt   = sel_r + SEL_WIDTH'(1);
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, pointer and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      ptr_r     <= '0;
      sel_r     <= '0;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      ack_r     <= '0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      ptr_r     <= ptr_nxt;
      sel_r     <= sel_nxt;
      valid_r   <= valid_nxt;
      busy_r    <= busy_nxt;
      ack_r     <= ack_nxt;
      timeout_r <= timeout_nxt;
    end
  end

  assign sel_out     = sel_r;
  assign valid_out   = valid_r;
  assign busy_out    = busy_r;
  assign ack_out     = ack_r;
  assign timeout_out = timeout_r;

endmodule

// File: tb/tb_rr_mux32_arbiter.sv
// Directed self-checking bench for rr_mux32_arbiter: reset, wrap, full rotation, abort, async reset, watchdog.
module tb_rr_mux32_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_in;
  logic        resp_in;
  logic [4:0]  sel_out;
  logic        valid_out;
  logic [31:0] ack_out;
  logic        busy_out;
  logic        timeout_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_mux32_arbiter #(.NUM_REQ(32), .SEL_WIDTH(5), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .resp_in(resp_in),
    .sel_out(sel_out), .valid_out(valid_out), .ack_out(ack_out),
    .busy_out(busy_out), .timeout_out(timeout_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_in = 32'h0; resp_in = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_in = 32'h0; resp_in = 1'b0;
    #1;
    step();
    checks++; if (sel_out !== 5'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", sel_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid_out); end
    checks++; if (ack_out !== 32'h0) begin errors++; $display("FAIL reset_ack: got %h expected 0", ack_out); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy_out); end
    checks++; if (timeout_out !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %0b expected 0", timeout_out); end
    rst = 1'b0;
    step();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL idle_no_req_valid: got %0b expected 0", valid_out); end
    req_in = 32'h0000_0001;
    step();
    checks++; if (sel_out !== 5'd0) begin errors++; $display("FAIL first_grant_sel: got %0d expected 0", sel_out); end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL first_grant_valid: got %0b expected 1", valid_out); end
    checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL first_grant_busy: got %0b expected 1", busy_out); end
    resp_in = 1'b1;
    step();
    resp_in = 1'b0; req_in = 32'h0;
    checks++; if (ack_out !== 32'h0000_0001) begin errors++; $display("FAIL first_ack: got %h expected 00000001", ack_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL done_valid: got %0b expected 0", valid_out); end
    step();
    checks++; if (ack_out !== 32'h0) begin errors++; $display("FAIL ack_one_cycle: got %h expected 0", ack_out); end
  endtask

  // ptr is 1 here, so 31 must win first, then the wrap to 0.
  task automatic test_wrap();
    logic [4:0] exp_sel [4];
    exp_sel[0] = 5'd31; exp_sel[1] = 5'd0; exp_sel[2] = 5'd31; exp_sel[3] = 5'd0;
    req_in = 32'h8000_0001;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (sel_out !== exp_sel[k] || valid_out !== 1'b1) begin errors++; $display("FAIL wrap_grant[%0d]: got sel %0d valid %0b expected sel %0d valid 1", k, sel_out, valid_out, exp_sel[k]); end
      resp_in = 1'b1;
      step();
      resp_in = 1'b0;
      checks++; if (ack_out !== (32'h1 << exp_sel[k])) begin errors++; $display("FAIL wrap_ack[%0d]: got %h expected %h", k, ack_out, 32'h1 << exp_sel[k]); end
      step();
    end
    req_in = 32'h0;
    step();
  endtask

  task automatic test_all_ones();
    logic [4:0] exp_sel;
    do_reset();
    req_in = 32'hFFFF_FFFF;
    for (int k = 0; k < 33; k++) begin
      exp_sel = 5'(k % 32);
      step();
      checks++; if (sel_out !== exp_sel || valid_out !== 1'b1) begin errors++; $display("FAIL rotate_grant[%0d]: got sel %0d valid %0b expected sel %0d valid 1", k, sel_out, valid_out, exp_sel); end
      resp_in = 1'b1;
      step();
      resp_in = 1'b0;
      checks++; if (ack_out !== (32'h1 << exp_sel) || $countones(ack_out) != 1) begin errors++; $display("FAIL rotate_ack[%0d]: got %h expected %h", k, ack_out, 32'h1 << exp_sel); end
      step();
    end
    req_in = 32'h0;
    step();
  endtask

  task automatic test_abort();
    do_reset();
    req_in = 32'h0000_0010;
    step();
    checks++; if (sel_out !== 5'd4) begin errors++; $display("FAIL abort_pre_sel: got %0d expected 4", sel_out); end
    resp_in = 1'b1;
    step();
    resp_in = 1'b0;
    step();
    req_in = 32'h0000_0020;
    step();
    checks++; if (sel_out !== 5'd5 || valid_out !== 1'b1) begin errors++; $display("FAIL abort_grant: got sel %0d valid %0b expected sel 5 valid 1", sel_out, valid_out); end
    req_in = 32'h0;
    step();
    checks++; if (valid_out !== 1'b0 || busy_out !== 1'b0) begin errors++; $display("FAIL abort_idle: got valid %0b busy %0b expected 0 0", valid_out, busy_out); end
    checks++; if (ack_out !== 32'h0) begin errors++; $display("FAIL abort_no_ack: got %h expected 0", ack_out); end
    resp_in = 1'b1;
    step();
    resp_in = 1'b0;
    checks++; if (ack_out !== 32'h0 || valid_out !== 1'b0) begin errors++; $display("FAIL stray_resp: got ack %h valid %0b expected 0 0", ack_out, valid_out); end
    // ptr must still be 5: with 4 and 5 pending, 5 wins; an advanced ptr would pick 4.
    req_in = 32'h0000_0030;
    step();
    checks++; if (sel_out !== 5'd5) begin errors++; $display("FAIL abort_ptr_kept: got %0d expected 5", sel_out); end
    req_in = 32'h0; resp_in = 1'b1;
    step();
    resp_in = 1'b0;
    checks++; if (ack_out !== 32'h0000_0020) begin errors++; $display("FAIL abort_resp_same_cycle: got %h expected 00000020", ack_out); end
    step();
    checks++; if (ack_out !== 32'h0) begin errors++; $display("FAIL abort_ack_clear: got %h expected 0", ack_out); end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    req_in = 32'h0010_0200;
    step();
    checks++; if (sel_out !== 5'd9 || busy_out !== 1'b1) begin errors++; $display("FAIL mid_busy_grant: got sel %0d busy %0b expected sel 9 busy 1", sel_out, busy_out); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (sel_out !== 5'd0 || valid_out !== 1'b0 || busy_out !== 1'b0 || ack_out !== 32'h0) begin errors++; $display("FAIL async_reset: got sel %0d valid %0b busy %0b ack %h expected all 0", sel_out, valid_out, busy_out, ack_out); end
    rst = 1'b0;
    step();
    checks++; if (sel_out !== 5'd9 || valid_out !== 1'b1) begin errors++; $display("FAIL post_reset_grant: got sel %0d valid %0b expected sel 9 valid 1", sel_out, valid_out); end
    req_in = 32'h0;
    step();
    step();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req_in = 32'h0000_0018;
    step();
    checks++; if (sel_out !== 5'd3) begin errors++; $display("FAIL timeout_grant: got %0d expected 3", sel_out); end
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++; if (valid_out !== 1'b1 || timeout_out !== 1'b0) begin errors++; $display("FAIL timeout_wait[%0d]: got valid %0b timeout %0b expected 1 0", k, valid_out, timeout_out); end
    end
    step();
    checks++; if (timeout_out !== 1'b1 || ack_out !== 32'h0 || valid_out !== 1'b0) begin errors++; $display("FAIL timeout_pulse: got timeout %0b ack %h valid %0b expected 1 0 0", timeout_out, ack_out, valid_out); end
    step();
    checks++; if (timeout_out !== 1'b0 || sel_out !== 5'd4 || valid_out !== 1'b1) begin errors++; $display("FAIL timeout_skip: got timeout %0b sel %0d valid %0b expected 0 4 1", timeout_out, sel_out, valid_out); end
    req_in = 32'h0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_wrap();
    test_all_ones();
    test_abort();
    test_reset_mid_busy();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
